// File: rtl/datapath_pkg.sv
// Shared definitions for the 16-bit CPU datapath: widths, ALU and shift codes.
// Imported by the register file and the datapath top.
package datapath_pkg;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int RIDX  = $clog2(NREGS);

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_MVN = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

endpackage

// File: rtl/datapath_regfile.sv
// 8 x 16 register file: one synchronous write port, one combinational read port.
// Ports: clk, reset (sync, active-high), write/writenum/data_in, readnum/data_out.
module datapath_regfile
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [2:0]  writenum,
    input  logic [15:0] data_in,
    input  logic [2:0]  readnum,
    output logic [15:0] data_out
);

    // Kept as named registers so they are visible by name from outside.
    logic [WIDTH-1:0] R0, R1, R2, R3, R4, R5, R6, R7;

    always_ff @(posedge clk) begin
        if (reset) begin
            R0 <= '0;
            R1 <= '0;
            R2 <= '0;
            R3 <= '0;
            R4 <= '0;
            R5 <= '0;
            R6 <= '0;
            R7 <= '0;
        end else if (write) begin
            unique case (writenum)
                3'd0: R0 <= data_in;
                3'd1: R1 <= data_in;
                3'd2: R2 <= data_in;
                3'd3: R3 <= data_in;
                3'd4: R4 <= data_in;
                3'd5: R5 <= data_in;
                3'd6: R6 <= data_in;
                3'd7: R7 <= data_in;
            endcase
        end
    end

    // No write bypass: a read of the register being written sees the old value.
    always_comb begin
        data_out = '0;
        unique case (readnum)
            3'd0: data_out = R0;
            3'd1: data_out = R1;
            3'd2: data_out = R2;
            3'd3: data_out = R3;
            3'd4: data_out = R4;
            3'd5: data_out = R5;
            3'd6: data_out = R6;
            3'd7: data_out = R7;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// 16-bit CPU datapath: register file, A/B operands, shifter, 4-op ALU, C and Z.
// Ports: clk, reset (sync, active-high), register-file controls (readnum,
// writenum, write, vsel), operand/result strobes (loada, loadb, loadc, loads),
// shift, asel, bsel, ALUop, datapath_in; outputs Z_out, datapath_out (= C).
module datapath
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  readnum,
    input  logic        vsel,
    input  logic        loada,
    input  logic        loadb,
    input  logic [1:0]  shift,
    input  logic        asel,
    input  logic        bsel,
    input  logic [1:0]  ALUop,
    input  logic        loadc,
    input  logic        loads,
    input  logic [2:0]  writenum,
    input  logic        write,
    input  logic [15:0] datapath_in,
    output logic        Z_out,
    output logic [15:0] datapath_out
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic             r_z;

    logic [WIDTH-1:0] w_wb;
    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] w_sh;
    logic [WIDTH-1:0] w_ain;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_alu;

    // Write-back from C uses the value held before the edge.
    assign w_wb = vsel ? datapath_in : r_c;

    datapath_regfile REGFILE (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .data_in  (w_wb),
        .readnum  (readnum),
        .data_out (w_rd)
    );

    always_comb begin
        w_sh = r_b;
        unique case (shift_e'(shift))
            SH_NONE: w_sh = r_b;
            SH_LSL:  w_sh = {r_b[WIDTH-2:0], 1'b0};
            SH_LSR:  w_sh = {1'b0, r_b[WIDTH-1:1]};
            SH_ASR:  w_sh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
        endcase
    end

    assign w_ain = asel ? '0 : r_a;
    assign w_bin = bsel ? {11'b0, datapath_in[4:0]} : w_sh;

    always_comb begin
        w_alu = '0;
        unique case (alu_op_e'(ALUop))
            ALU_ADD: w_alu = w_ain + w_bin;
            ALU_SUB: w_alu = w_ain - w_bin;
            ALU_AND: w_alu = w_ain & w_bin;
            ALU_MVN: w_alu = ~w_bin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
            r_z <= 1'b0;
        end else begin
            if (loada) r_a <= w_rd;
            if (loadb) r_b <= w_rd;
            if (loadc) r_c <= w_alu;
            // Z tracks the live ALU result, independent of loadc.
            if (loads) r_z <= (w_alu == '0);
        end
    end

    assign datapath_out = r_c;
    assign Z_out        = r_z;

endmodule

// File: tb/tb_datapath.sv
// Directed testbench for datapath: table of ALU/shift vectors plus
// hand-written sequences for reset, write-back, Z hold and same-edge cases.
module tb_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  readnum;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [2:0]  writenum;
    logic        write;
    logic [15:0] datapath_in;
    logic        Z_out;
    logic [15:0] datapath_out;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    datapath DUT (
        .clk          (clk),
        .reset        (reset),
        .readnum      (readnum),
        .vsel         (vsel),
        .loada        (loada),
        .loadb        (loadb),
        .shift        (shift),
        .asel         (asel),
        .bsel         (bsel),
        .ALUop        (ALUop),
        .loadc        (loadc),
        .loads        (loads),
        .writenum     (writenum),
        .write        (write),
        .datapath_in  (datapath_in),
        .Z_out        (Z_out),
        .datapath_out (datapath_out)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  sh;
        logic        as;
        logic        bs;
        logic [1:0]  op;
        logic [15:0] imm;
        logic [15:0] ec;
        logic        ez;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [15:0] rf(input int i);
        case (i)
            0: rf = DUT.REGFILE.R0;
            1: rf = DUT.REGFILE.R1;
            2: rf = DUT.REGFILE.R2;
            3: rf = DUT.REGFILE.R3;
            4: rf = DUT.REGFILE.R4;
            5: rf = DUT.REGFILE.R5;
            6: rf = DUT.REGFILE.R6;
            default: rf = DUT.REGFILE.R7;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; readnum = 0; vsel = 0; loada = 0; loadb = 0;
        shift = 0; asel = 0; bsel = 0; ALUop = 0; loadc = 0;
        loads = 0; writenum = 0; write = 0; datapath_in = 0;
    endtask

    task automatic wr_imm(input logic [2:0] n, input logic [15:0] v);
        idle();
        vsel = 1; write = 1; writenum = n; datapath_in = v;
        cyc();
        idle();
    endtask

    task automatic load_ab(input logic [2:0] ra, input logic [2:0] rb);
        idle();
        readnum = ra; loada = 1;
        cyc();
        idle();
        readnum = rb; loadb = 1;
        cyc();
        idle();
    endtask

    task automatic compute(input logic [1:0] sh, input logic as,
                           input logic bs, input logic [1:0] op,
                           input logic [15:0] imm, input logic lc,
                           input logic ls);
        idle();
        shift = sh; asel = as; bsel = bs; ALUop = op;
        datapath_in = imm; loadc = lc; loads = ls;
        cyc();
        idle();
    endtask

    initial begin
        //            a        b        sh    as bs op     imm      ec       ez
        vecs[0]  = '{16'd50,  16'd21,  2'b00, 0, 0, 2'b00, 16'h0000, 16'd71,  0};
        vecs[1]  = '{16'd50,  16'd50,  2'b00, 0, 0, 2'b01, 16'h0000, 16'h0000, 1};
        vecs[2]  = '{16'h0000, 16'h8003, 2'b01, 1, 0, 2'b00, 16'h0000, 16'h0006, 0};
        vecs[3]  = '{16'h0000, 16'h8003, 2'b10, 1, 0, 2'b00, 16'h0000, 16'h4001, 0};
        vecs[4]  = '{16'h0000, 16'h8003, 2'b11, 1, 0, 2'b00, 16'h0000, 16'hC001, 0};
        vecs[5]  = '{16'h1234, 16'h8003, 2'b11, 0, 0, 2'b11, 16'h0000, 16'h3FFE, 0};
        vecs[6]  = '{16'h1234, 16'h5555, 2'b00, 1, 1, 2'b00, 16'hFFF7, 16'h0017, 0};
        vecs[7]  = '{16'hF0F0, 16'h0FF0, 2'b00, 0, 0, 2'b10, 16'h0000, 16'h00F0, 0};
        vecs[8]  = '{16'd5,   16'd7,   2'b00, 0, 0, 2'b01, 16'h0000, 16'hFFFE, 0};
        vecs[9]  = '{16'hFFFF, 16'h0001, 2'b00, 0, 0, 2'b00, 16'h0000, 16'h0000, 1};
        vecs[10] = '{16'h0100, 16'h9999, 2'b00, 0, 1, 2'b00, 16'hAB3F, 16'h011F, 0};
        vecs[11] = '{16'h0000, 16'h0002, 2'b10, 0, 0, 2'b11, 16'h0000, 16'hFFFE, 0};
        vecs[12] = '{16'h0000, 16'h8000, 2'b01, 1, 0, 2'b00, 16'h0000, 16'h0000, 1};

        idle();
        reset = 1;
        cyc();
        idle();
        for (int i = 0; i < 8; i++)
            chk($sformatf("reset_R%0d", i), rf(i), 16'h0);
        chk("reset_out", datapath_out, 16'h0);
        chk("reset_Z", {15'b0, Z_out}, 16'h0);

        // MOV immediates and ADD with write-back of C.
        wr_imm(0, 16'd50);
        wr_imm(1, 16'd21);
        chk("mov_R0", rf(0), 16'd50);
        chk("mov_R1", rf(1), 16'd21);
        load_ab(0, 1);
        compute(2'b00, 0, 0, 2'b00, 16'h0, 1, 1);
        chk("add_out", datapath_out, 16'd71);
        chk("add_Z", {15'b0, Z_out}, 16'h0);
        idle();
        write = 1; vsel = 0; writenum = 2;
        cyc();
        idle();
        chk("wb_R2", rf(2), 16'd71);

        // Zero result with loads low: C updates, Z holds 0; then Z sets.
        load_ab(0, 0);
        compute(2'b00, 0, 0, 2'b01, 16'h0, 1, 0);
        chk("hold_out", datapath_out, 16'h0);
        chk("hold_Z", {15'b0, Z_out}, 16'h0);
        compute(2'b00, 0, 0, 2'b01, 16'h0, 0, 1);
        chk("setz_Z", {15'b0, Z_out}, 16'h1);

        // Table vectors.
        for (int i = 0; i < 13; i++) begin
            wr_imm(0, vecs[i].a);
            wr_imm(1, vecs[i].b);
            load_ab(0, 1);
            compute(vecs[i].sh, vecs[i].as, vecs[i].bs, vecs[i].op,
                    vecs[i].imm, 1, 1);
            chk($sformatf("vec%0d_out", i), datapath_out, vecs[i].ec);
            chk($sformatf("vec%0d_Z", i), {15'b0, Z_out}, {15'b0, vecs[i].ez});
        end

        // Read of a register being written returns the old value.
        wr_imm(3, 16'h1234);
        idle();
        vsel = 1; write = 1; writenum = 3; datapath_in = 16'h5555;
        readnum = 3; loada = 1;
        cyc();
        idle();
        chk("nobyp_R3", rf(3), 16'h5555);
        compute(2'b00, 0, 1, 2'b00, 16'h0000, 1, 1);
        chk("nobyp_A", datapath_out, 16'h1234);

        // Write-back with loadc on the same edge stores the old C.
        wr_imm(1, 16'h0010);
        load_ab(3, 1);
        idle();
        asel = 0; bsel = 0; ALUop = 2'b00; loadc = 1;
        write = 1; vsel = 0; writenum = 4;
        cyc();
        idle();
        chk("same_R4", rf(4), 16'h1234);
        chk("same_out", datapath_out, 16'h5565);

        // Reset wins over loadc/loads/write in the same cycle.
        idle();
        reset = 1; loadc = 1; loads = 1; write = 1; vsel = 1;
        writenum = 5; datapath_in = 16'h7777;
        asel = 1; bsel = 1; ALUop = 2'b00;
        cyc();
        idle();
        chk("rstpri_out", datapath_out, 16'h0);
        chk("rstpri_Z", {15'b0, Z_out}, 16'h0);
        chk("rstpri_R5", rf(5), 16'h0);
        chk("rstpri_R4", rf(4), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
